data_path: RTL and testbench
============================

# data_path

Single-bus 32-bit CPU datapath: general-purpose register file, PC, IR, MAR/MDR, Y, 64-bit Z, HI/LO, in-port and out-port registers, a combinational ALU and a 512-word RAM. All blocks share one 32-bit bus. The block is sequenced externally by a control unit or testbench that drives one-hot "out" (bus source) and "enable" (load) strobes each cycle. It sits between the control unit and the I/O devices.

## Interface
- No parameters.
- Clock  in  1  rising-edge clock for every register and RAM write.
- clr  in  1  synchronous, active-low reset.
- Mdatain  out  32  RAM read data, RAM[MAR[8:0]]; combinational.
- MDR_data_out  out  32  current MDR contents.
- PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out, in_port_out  in  1 each  bus-source strobes.
- MDR_enable, MAR_enable, Z_enable, Y_enable, PC_enable, LO_enable, HI_enable, IR_enable  in  1 each  register load strobes.
- InPort  in  32  external input-device data.
- IncPC  in  1  forces the ALU to compute bus+1.
- Read  in  1  MDR input mux: 1 = RAM data, 0 = bus.
- opcode  in  5  ALU operation select.
- con_in  in  1  loads the CON flip-flop.
- out_port_enable  in  1  loads the out-port register from the bus.
- RAM_write_enable  in  1  writes MDR to RAM[MAR[8:0]].
- Gra, Grb, Grc  in  1 each  select the IR Ra, Rb or Rc field as the register index.
- R_in, R_out, BA_out  in  1 each  register write, register read, and base-address read (R0 reads as 0).
- in_port_enable  in  1  loads the in-port register from InPort.

## Operation
- Bus source priority, highest first: MDR_out, PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, in_port_out, R_out/BA_out. If no source is asserted, the bus is 0.
- IR fields:
  - Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
  - C = IR[18:0] sign-extended to 32 bits.
  - Condition = IR[20:19].
- Register index is Ra, Rb or Rc according to Gra/Grb/Grc. If more than one is set, Gra wins over Grb, and Grb over Grc.
- R_in writes the bus into R[index].
- R_out drives R[index] onto the bus.
- BA_out drives R[index] onto the bus, except that index 0 drives 0.
- R0 is a real, writable register.
- ALU: A = Y, B = bus, 64-bit result loaded into Z {ZHi, ZLo} when Z_enable is asserted. IncPC overrides opcode with ZLo = B+1, ZHi = 0.
  - 00000 (ld), 00001 (ldi), 00010 (st), 00011 (add), 01100 (addi): A+B.
  - 00100: A−B.
  - 00101 / 01101: A&B.
  - 00110 / 01110: A|B.
  - 00111: ror A by B[4:0].
  - 01000: rol A by B[4:0].
  - 01001: shr (logical) A by B[4:0].
  - 01010: shra (arithmetic) A by B[4:0].
  - 01011: shl A by B[4:0].
  - 01111: signed divide. ZLo = quotient, ZHi = remainder (truncate toward zero). If B = 0, Z = 0.
  - 10000: signed multiply, full 64-bit product.
  - 10001: neg B (−B).
  - 10010: not B (~B).
  - Any other opcode: Z = 0.
  - For every 32-bit result, ZHi = 0.
- MDR loads on MDR_enable: RAM[MAR[8:0]] if Read = 1, otherwise the bus.
- RAM: 512×32, write-only through MDR, address MAR[8:0]. RAM is not cleared by reset; the bench preloads it hierarchically.
- CON: on con_in, CON ← condition met on R[Ra]. Conditions: 00 = zero, 01 = nonzero, 10 = positive (≥0, MSB clear), 11 = negative.
- Out-port register and CON are internal state with no port; they are observed hierarchically.

## Timing
- All loads take effect on the rising Clock edge. The bus, ALU, C, Mdatain and the select/encode logic are combinational.
- Z captures the ALU result in the same cycle its operands are on Y and the bus.
- Memory read takes 2 cycles: MAR loaded at edge n, then MDR captures RAM[MAR] at edge n+1 with Read = 1 and MDR_enable = 1.
- A RAM write at edge n is visible on Mdatain after the edge.
- Reset: when clr = 0 at an edge, the following all load 0 and take priority over any load strobe:
  - R0–R15, PC, IR, MAR, MDR, Y, Z, HI, LO, in-port, out-port, CON.
- Reset output values: MDR_data_out = 0; Mdatain = RAM[0].
- Reset asserted mid-sequence clears state on that edge. The sequence must be restarted.
- A register that has no strobe asserted holds its value.

## Test plan
- Reset: load R1 and PC with nonzero values, then hold clr = 0 for one edge → all registers are 0 and MDR_data_out = 0.
- Fetch: RAM[0] = 0x09800000, PC = 0.
  - T0: PC_out, MAR_enable, IncPC, Z_enable.
  - T1: ZLow_out, PC_enable, Read, MDR_enable.
  - T2: MDR_out, IR_enable.
  - Required: IR = 0x09800000, PC = 1, MDR_data_out = 0x09800000.
- In-port: InPort = 0x12345678, pulse in_port_enable. With IR Ra = 3, assert Gra, in_port_out, R_in → R3 = 0x12345678.
- Add: R1 = 5, R2 = 7, IR Ra = 4, Rb = 1, Rc = 2.
  - Step 1: Grb, R_out, Y_enable.
  - Step 2: Grc, R_out, opcode 00011, Z_enable.
  - Step 3: ZLow_out, Gra, R_in.
  - Required: R4 = 12.
- Mul/div:
  - Y = 0xFFFFFFFA (−6), bus = 4, mul → Z = 0xFFFFFFFF_FFFFFFE8.
  - Y = 17, bus = 5, div → ZLo = 3, ZHi = 2.
  - Bus = 0, div → Z = 0.
- Store and branch condition:
  - MAR = 0x10, MDR = 0xDEADBEEF, assert RAM_write_enable → Mdatain = 0xDEADBEEF.
  - R[Ra] = 0, condition 00, assert con_in → CON = 1.
  - Then R[Ra] = 0xFFFFFFFF, condition 00, assert con_in → CON = 0.

Source files
------------

// File: rtl/data_path.sv
// Single-bus 32-bit CPU datapath: register file, PC/IR/MAR/MDR, Y, 64-bit Z, HI/LO,
// I/O port registers, combinational ALU and a 512-word RAM, all sequenced by external strobes.
module data_path (
    input  logic        Clock,
    input  logic        clr,
    output logic [31:0] Mdatain,
    output logic [31:0] MDR_data_out,
    input  logic        PC_out,
    input  logic        ZHigh_out,
    input  logic        ZLow_out,
    input  logic        HI_out,
    input  logic        LO_out,
    input  logic        C_out,
    input  logic        MDR_out,
    input  logic        in_port_out,
    input  logic        MDR_enable,
    input  logic        MAR_enable,
    input  logic        Z_enable,
    input  logic        Y_enable,
    input  logic        PC_enable,
    input  logic        LO_enable,
    input  logic        HI_enable,
    input  logic        IR_enable,
    input  logic [31:0] InPort,
    input  logic        IncPC,
    input  logic        Read,
    input  logic [4:0]  opcode,
    input  logic        con_in,
    input  logic        out_port_enable,
    input  logic        RAM_write_enable,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        R_in,
    input  logic        R_out,
    input  logic        BA_out,
    input  logic        in_port_enable
);

    logic [31:0] r_regFile [0:15];
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_mar;
    logic [31:0] r_mdr;
    logic [31:0] r_y;
    logic [31:0] r_zHi;
    logic [31:0] r_zLo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_inPort;
    logic [31:0] r_outPort;
    logic        r_con;
    logic [31:0] r_ram [0:511];

    logic [3:0]  w_regIdx;
    logic [31:0] w_regVal;
    logic [31:0] w_cSignExt;
    logic [31:0] w_bus;
    logic [63:0] w_aluResult;
    logic [4:0]  w_shamt;
    logic [63:0] w_rorWide;
    logic [63:0] w_rolWide;
    logic signed [31:0] w_ySigned;
    logic signed [31:0] w_divisor;
    logic signed [31:0] w_quotient;
    logic signed [31:0] w_remainder;
    logic signed [63:0] w_product;
    logic [31:0] w_raVal;
    logic        w_condMet;

    always_comb begin
        w_regIdx = r_ir[18:15];
        if (Gra)
            w_regIdx = r_ir[26:23];
        else if (Grb)
            w_regIdx = r_ir[22:19];
    end

    assign w_regVal   = r_regFile[w_regIdx];
    assign w_cSignExt = {{13{r_ir[18]}}, r_ir[18:0]};

    always_comb begin
        w_bus = 32'd0;
        if (MDR_out)
            w_bus = r_mdr;
        else if (PC_out)
            w_bus = r_pc;
        else if (ZHigh_out)
            w_bus = r_zHi;
        else if (ZLow_out)
            w_bus = r_zLo;
        else if (HI_out)
            w_bus = r_hi;
        else if (LO_out)
            w_bus = r_lo;
        else if (C_out)
            w_bus = w_cSignExt;
        else if (in_port_out)
            w_bus = r_inPort;
        else if (R_out)
            w_bus = w_regVal;
        else if (BA_out)
            w_bus = (w_regIdx == 4'd0) ? 32'd0 : w_regVal;
    end

    // A zero divisor is replaced by 1 so the divider never produces X; the result is forced to 0 below.
    assign w_shamt     = w_bus[4:0];
    assign w_rorWide   = {r_y, r_y} >> w_shamt;
    assign w_rolWide   = {r_y, r_y} << w_shamt;
    assign w_ySigned   = r_y;
    assign w_divisor   = (w_bus == 32'd0) ? 32'sd1 : w_bus;
    assign w_quotient  = w_ySigned / w_divisor;
    assign w_remainder = w_ySigned % w_divisor;
    assign w_product   = $signed({{32{r_y[31]}}, r_y}) * $signed({{32{w_bus[31]}}, w_bus});

    always_comb begin
        w_aluResult = 64'd0;
        if (IncPC) begin
            w_aluResult = {32'd0, w_bus + 32'd1};
        end else begin
            case (opcode)
                5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01100:
                    w_aluResult = {32'd0, r_y + w_bus};
                5'b00100: w_aluResult = {32'd0, r_y - w_bus};
                5'b00101, 5'b01101: w_aluResult = {32'd0, r_y & w_bus};
                5'b00110, 5'b01110: w_aluResult = {32'd0, r_y | w_bus};
                5'b00111: w_aluResult = {32'd0, w_rorWide[31:0]};
                5'b01000: w_aluResult = {32'd0, w_rolWide[63:32]};
                5'b01001: w_aluResult = {32'd0, r_y >> w_shamt};
                5'b01010: w_aluResult = {32'd0, 32'(w_ySigned >>> w_shamt)};
                5'b01011: w_aluResult = {32'd0, r_y << w_shamt};
                5'b01111: begin
                    if (w_bus != 32'd0)
                        w_aluResult = {w_remainder, w_quotient};
                end
                5'b10000: w_aluResult = w_product;
                5'b10001: w_aluResult = {32'd0, 32'd0 - w_bus};
                5'b10010: w_aluResult = {32'd0, ~w_bus};
                default:  w_aluResult = 64'd0;
            endcase
        end
    end

    assign w_raVal = r_regFile[r_ir[26:23]];

    always_comb begin
        case (r_ir[20:19])
            2'b00:   w_condMet = (w_raVal == 32'd0);
            2'b01:   w_condMet = (w_raVal != 32'd0);
            2'b10:   w_condMet = ~w_raVal[31];
            default: w_condMet = w_raVal[31];
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!clr) begin
            for (int i = 0; i < 16; i++)
                r_regFile[i] <= 32'd0;
            r_pc      <= 32'd0;
            r_ir      <= 32'd0;
            r_mar     <= 32'd0;
            r_mdr     <= 32'd0;
            r_y       <= 32'd0;
            r_zHi     <= 32'd0;
            r_zLo     <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_inPort  <= 32'd0;
            r_outPort <= 32'd0;
            r_con     <= 1'b0;
        end else begin
            if (R_in)
                r_regFile[w_regIdx] <= w_bus;
            if (PC_enable)
                r_pc <= w_bus;
            if (IR_enable)
                r_ir <= w_bus;
            if (MAR_enable)
                r_mar <= w_bus;
            if (MDR_enable)
                r_mdr <= Read ? Mdatain : w_bus;
            if (Y_enable)
                r_y <= w_bus;
            if (Z_enable) begin
                r_zHi <= w_aluResult[63:32];
                r_zLo <= w_aluResult[31:0];
            end
            if (HI_enable)
                r_hi <= w_bus;
            if (LO_enable)
                r_lo <= w_bus;
            if (in_port_enable)
                r_inPort <= InPort;
            if (out_port_enable)
                r_outPort <= w_bus;
            if (con_in)
                r_con <= w_condMet;
        end
    end

    // RAM contents survive reset; only MDR can write it.
    always_ff @(posedge Clock) begin
        if (RAM_write_enable)
            r_ram[r_mar[8:0]] <= r_mdr;
    end

    assign Mdatain      = r_ram[r_mar[8:0]];
    assign MDR_data_out = r_mdr;

endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: stimulus queues expected register values, a negedge monitor pops and compares.
module tb_data_path;

    logic        Clock = 1'b0;
    logic        clr;
    logic [31:0] Mdatain, MDR_data_out;
    logic        PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out, in_port_out;
    logic        MDR_enable, MAR_enable, Z_enable, Y_enable, PC_enable, LO_enable, HI_enable, IR_enable;
    logic [31:0] InPort;
    logic        IncPC, Read, con_in, out_port_enable, RAM_write_enable;
    logic [4:0]  opcode;
    logic        Gra, Grb, Grc, R_in, R_out, BA_out, in_port_enable;

    int errorCount = 0;
    int checkCount = 0;

    localparam int K_REG = 0, K_PC = 1, K_IR = 2, K_MDROUT = 3, K_MDATAIN = 4, K_ZHI = 5,
                   K_ZLO = 6, K_CON = 7, K_Y = 8, K_OUTPORT = 9;

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [31:0] expVal;
    } expect_t;

    expect_t scoreQ[$];

    data_path dut (
        .Clock(Clock), .clr(clr), .Mdatain(Mdatain), .MDR_data_out(MDR_data_out),
        .PC_out(PC_out), .ZHigh_out(ZHigh_out), .ZLow_out(ZLow_out), .HI_out(HI_out),
        .LO_out(LO_out), .C_out(C_out), .MDR_out(MDR_out), .in_port_out(in_port_out),
        .MDR_enable(MDR_enable), .MAR_enable(MAR_enable), .Z_enable(Z_enable),
        .Y_enable(Y_enable), .PC_enable(PC_enable), .LO_enable(LO_enable),
        .HI_enable(HI_enable), .IR_enable(IR_enable), .InPort(InPort), .IncPC(IncPC),
        .Read(Read), .opcode(opcode), .con_in(con_in), .out_port_enable(out_port_enable),
        .RAM_write_enable(RAM_write_enable), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .R_in(R_in), .R_out(R_out), .BA_out(BA_out), .in_port_enable(in_port_enable)
    );

    always #5 Clock = ~Clock;

    function automatic logic [31:0] observe(input int kind, input int idx);
        case (kind)
            K_REG:     return dut.r_regFile[idx];
            K_PC:      return dut.r_pc;
            K_IR:      return dut.r_ir;
            K_MDROUT:  return MDR_data_out;
            K_MDATAIN: return Mdatain;
            K_ZHI:     return dut.r_zHi;
            K_ZLO:     return dut.r_zLo;
            K_CON:     return {31'd0, dut.r_con};
            K_Y:       return dut.r_y;
            default:   return dut.r_outPort;
        endcase
    endfunction

    task automatic checkOutput(input expect_t e);
        logic [31:0] actual;
        actual = observe(e.kind, e.idx);
        checkCount++;
        if (actual !== e.expVal) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.name, actual, e.expVal);
        end
    endtask

    // Strobes are cleared right after each edge, so state is stable when the monitor samples.
    initial begin
        forever begin
            @(negedge Clock);
            while (scoreQ.size() > 0)
                checkOutput(scoreQ.pop_front());
        end
    end

    task automatic expectVal(input string name, input int kind, input int idx, input logic [31:0] v);
        expect_t e;
        e.name = name; e.kind = kind; e.idx = idx; e.expVal = v;
        scoreQ.push_back(e);
    endtask

    task automatic clearStrobes();
        {PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out, in_port_out} = '0;
        {MDR_enable, MAR_enable, Z_enable, Y_enable, PC_enable, LO_enable, HI_enable, IR_enable} = '0;
        {IncPC, Read, con_in, out_port_enable, RAM_write_enable} = '0;
        {Gra, Grb, Grc, R_in, R_out, BA_out, in_port_enable} = '0;
        opcode = 5'd0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        clearStrobes();
    endtask

    task automatic loadInPort(input logic [31:0] v);
        InPort = v; in_port_enable = 1'b1;
        tick();
    endtask

    task automatic setIR(input logic [31:0] v);
        loadInPort(v);
        in_port_out = 1'b1; IR_enable = 1'b1;
        tick();
    endtask

    task automatic setReg(input logic [3:0] idx, input logic [31:0] v);
        setIR({5'd0, idx, 23'd0});
        loadInPort(v);
        in_port_out = 1'b1; Gra = 1'b1; R_in = 1'b1;
        tick();
    endtask

    task automatic aluCase(input string name, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
        loadInPort(a);
        in_port_out = 1'b1; Y_enable = 1'b1;
        tick();
        loadInPort(b);
        in_port_out = 1'b1; opcode = op; Z_enable = 1'b1;
        tick();
        expectVal({name, "_zhi"}, K_ZHI, 0, expHi);
        expectVal({name, "_zlo"}, K_ZLO, 0, expLo);
    endtask

    task automatic applyStimulus();
        clearStrobes();
        InPort = 32'd0;
        clr = 1'b0;
        dut.r_ram[0] = 32'h0980_0000;
        tick();
        clr = 1'b1;

        // Dirty a few registers, then reset for a single edge.
        setReg(4'd1, 32'h0000_0055);
        loadInPort(32'h0000_0040);
        in_port_out = 1'b1; PC_enable = 1'b1; Y_enable = 1'b1;
        tick();
        clr = 1'b0;
        PC_enable = 1'b1; in_port_out = 1'b1;
        tick();
        clr = 1'b1;
        expectVal("rst_r1", K_REG, 1, 32'd0);
        expectVal("rst_pc", K_PC, 0, 32'd0);
        expectVal("rst_y", K_Y, 0, 32'd0);
        expectVal("rst_ir", K_IR, 0, 32'd0);
        expectVal("rst_mdr", K_MDROUT, 0, 32'd0);
        expectVal("rst_mdatain", K_MDATAIN, 0, 32'h0980_0000);

        PC_out = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; Z_enable = 1'b1;
        tick();
        ZLow_out = 1'b1; PC_enable = 1'b1; Read = 1'b1; MDR_enable = 1'b1;
        tick();
        MDR_out = 1'b1; IR_enable = 1'b1;
        tick();
        expectVal("fetch_ir", K_IR, 0, 32'h0980_0000);
        expectVal("fetch_pc", K_PC, 0, 32'd1);
        expectVal("fetch_mdr", K_MDROUT, 0, 32'h0980_0000);

        // IR Ra is 3 after the fetch.
        loadInPort(32'h1234_5678);
        Gra = 1'b1; in_port_out = 1'b1; R_in = 1'b1;
        tick();
        expectVal("inport_r3", K_REG, 3, 32'h1234_5678);

        // MDR_out beats PC_out on the bus.
        MDR_out = 1'b1; PC_out = 1'b1; Y_enable = 1'b1;
        tick();
        expectVal("bus_priority", K_Y, 0, 32'h0980_0000);

        setReg(4'd1, 32'd5);
        setReg(4'd2, 32'd7);
        setIR(32'h0209_0000);
        Grb = 1'b1; R_out = 1'b1; Y_enable = 1'b1;
        tick();
        Grc = 1'b1; R_out = 1'b1; opcode = 5'b00011; Z_enable = 1'b1;
        tick();
        ZLow_out = 1'b1; Gra = 1'b1; R_in = 1'b1;
        tick();
        expectVal("add_r4", K_REG, 4, 32'd12);

        aluCase("mul", 5'b10000, 32'hFFFF_FFFA, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFE8);
        aluCase("div", 5'b01111, 32'd17, 32'd5, 32'd2, 32'd3);
        aluCase("div0", 5'b01111, 32'd17, 32'd0, 32'd0, 32'd0);
        aluCase("divneg", 5'b01111, 32'hFFFF_FFEF, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        aluCase("sub", 5'b00100, 32'd3, 32'd5, 32'd0, 32'hFFFF_FFFE);
        aluCase("and", 5'b00101, 32'hF0F0_FFFF, 32'h0FF0_F00F, 32'd0, 32'h00F0_F00F);
        aluCase("ror", 5'b00111, 32'd1, 32'd1, 32'd0, 32'h8000_0000);
        aluCase("rol", 5'b01000, 32'h8000_0000, 32'd1, 32'd0, 32'd1);
        aluCase("shr", 5'b01001, 32'h8000_0000, 32'd4, 32'd0, 32'h0800_0000);
        aluCase("shra", 5'b01010, 32'h8000_0000, 32'd4, 32'd0, 32'hF800_0000);
        aluCase("shl", 5'b01011, 32'h0000_0003, 32'd31, 32'd0, 32'h8000_0000);
        aluCase("neg", 5'b10001, 32'd0, 32'd5, 32'd0, 32'hFFFF_FFFB);
        aluCase("not", 5'b10010, 32'd0, 32'h0F0F_0F0F, 32'd0, 32'hF0F0_F0F0);
        aluCase("badop", 5'b11111, 32'd5, 32'd5, 32'd0, 32'd0);

        // BA_out reads R0 as zero even though R0 holds data; R_out does not.
        setReg(4'd0, 32'h0000_0077);
        BA_out = 1'b1; Gra = 1'b1; Y_enable = 1'b1;
        tick();
        expectVal("ba_r0", K_Y, 0, 32'd0);
        R_out = 1'b1; Gra = 1'b1; Y_enable = 1'b1;
        tick();
        expectVal("rout_r0", K_Y, 0, 32'h0000_0077);

        loadInPort(32'h0000_0010);
        in_port_out = 1'b1; MAR_enable = 1'b1;
        tick();
        loadInPort(32'hDEAD_BEEF);
        in_port_out = 1'b1; MDR_enable = 1'b1; out_port_enable = 1'b1;
        tick();
        RAM_write_enable = 1'b1;
        tick();
        expectVal("store_mdatain", K_MDATAIN, 0, 32'hDEAD_BEEF);
        expectVal("store_mdr", K_MDROUT, 0, 32'hDEAD_BEEF);
        expectVal("outport", K_OUTPORT, 0, 32'hDEAD_BEEF);

        setReg(4'd5, 32'd0);
        setIR(32'h0280_0000);
        con_in = 1'b1;
        tick();
        expectVal("con_zero", K_CON, 0, 32'd1);
        setReg(4'd5, 32'hFFFF_FFFF);
        setIR(32'h0280_0000);
        con_in = 1'b1;
        tick();
        expectVal("con_nonzero", K_CON, 0, 32'd0);
        setIR(32'h0298_0000);
        con_in = 1'b1;
        tick();
        expectVal("con_negative", K_CON, 0, 32'd1);
    endtask

    initial begin
        int waitCycles;
        applyStimulus();
        waitCycles = 0;
        while (scoreQ.size() > 0 && waitCycles < 20) begin
            @(posedge Clock);
            waitCycles++;
        end
        if (scoreQ.size() > 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", scoreQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
